// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with a runtime-loadable pattern and selectable overlap mode.
// Define MOORE_SEQ_DETECTOR_COUNT_EN to build the saturating match counter; otherwise match_cnt reads 0.
module moore_seq_detector #(
  parameter int             LEN      = 4,
  parameter logic [LEN-1:0] PAT_INIT = 4'b1010,
  parameter int             CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             i_valid,
  input  logic             overlap,
  input  logic             load,
  input  logic [LEN-1:0]   pattern_in,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(LEN);

  logic [LEN-1:0] pat_q, pat_d;
  logic [LEN-1:0] hist_q, hist_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           y_q, y_d;

  logic [LEN-1:0] hist_shift;
  logic [FW-1:0]  fill_inc;
  logic           match_ev;

  // Candidate state for a consumed bit; a match needs a full window that equals the pattern.
  assign hist_shift = {hist_q[LEN-2:0], i};
  assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  assign match_ev   = i_valid && !load && (hist_shift == pat_q) && (fill_inc == FILL_FULL);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    if (load) begin
      pat_d  = pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (i_valid) begin
      hist_d = hist_shift;
      fill_d = (match_ev && !overlap) ? '0 : fill_inc;
      y_d    = match_ev;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_INIT;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

`ifdef MOORE_SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (match_ev && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench for moore_seq_detector: a driver queues hand-computed expectations per edge,
// a negedge monitor pops and compares. Counter expectations collapse to 0 unless MOORE_SEQ_DETECTOR_COUNT_EN.
module tb_moore_seq_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i = 1'b0;
  logic       i_valid = 1'b0;
  logic       overlap = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       y, y_sat;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_sat;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       y;
    logic [7:0] cnt;
    logic [1:0] sat;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  moore_seq_detector dut (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .overlap(overlap),
    .load(load), .pattern_in(pattern_in), .y(y), .match_cnt(match_cnt)
  );

  moore_seq_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .overlap(overlap),
    .load(load), .pattern_in(pattern_in), .y(y_sat), .match_cnt(match_cnt_sat)
  );

  function automatic int ec(input int v);
`ifdef MOORE_SEQ_DETECTOR_COUNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, "y",         int'(y),             int'(e.y));
      check(e.tag, "match_cnt", int'(match_cnt),     int'(e.cnt));
      check(e.tag, "y_sat",     int'(y_sat),         int'(e.y));
      check(e.tag, "cnt_sat",   int'(match_cnt_sat), int'(e.sat));
    end
  end

  task automatic drive(input logic r, input logic ld, input logic [3:0] pat, input logic v,
                       input logic b, input logic ov, input logic ey, input int ecnt,
                       input int esat, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; pattern_in = pat; i_valid = v; i = b; overlap = ov;
    @(posedge clk);
    #1;
    e.y = ey; e.cnt = 8'(ec(ecnt)); e.sat = 2'(ec(esat)); e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic bitv(input logic b, input logic ov, input logic ey, input int ecnt, input string tag);
    drive(1'b0, 1'b0, 4'b0000, 1'b1, b, ov, ey, ecnt, ecnt, tag);
  endtask

  task automatic idle(input logic ey, input int ecnt, input string tag);
    drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, ey, ecnt, ecnt, tag);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset("reset0");
    do_reset("reset1");

    // Non-overlapping 1,0,1,0,1,0: one detection after the 4th bit.
    bitv(1, 0, 0, 0, "nov_b1"); bitv(0, 0, 0, 0, "nov_b2");
    bitv(1, 0, 0, 0, "nov_b3"); bitv(0, 0, 1, 1, "nov_b4");
    bitv(1, 0, 0, 1, "nov_b5"); bitv(0, 0, 0, 1, "nov_b6");
    do_reset("reset_a");

    // Overlapping: detections after the 4th and 6th bits.
    bitv(1, 1, 0, 0, "ov_b1"); bitv(0, 1, 0, 0, "ov_b2");
    bitv(1, 1, 0, 0, "ov_b3"); bitv(0, 1, 1, 1, "ov_b4");
    bitv(1, 1, 0, 1, "ov_b5"); bitv(0, 1, 1, 2, "ov_b6");
    do_reset("reset_b");

    // Reset mid-pattern discards the partial 1,0,1.
    bitv(1, 0, 0, 0, "mid_b1"); bitv(0, 0, 0, 0, "mid_b2"); bitv(1, 0, 0, 0, "mid_b3");
    do_reset("mid_rst");
    bitv(0, 0, 0, 0, "mid_b4");
    bitv(1, 0, 0, 0, "mid_c1"); bitv(0, 0, 0, 0, "mid_c2");
    bitv(1, 0, 0, 0, "mid_c3"); bitv(0, 0, 1, 1, "mid_c4");
    do_reset("reset_c");

    // Invalid gap between bits is not consumed; y drops on an idle cycle.
    bitv(1, 0, 0, 0, "gap_b1"); bitv(0, 0, 0, 0, "gap_b2");
    idle(0, 0, "gap_i1"); idle(0, 0, "gap_i2"); idle(0, 0, "gap_i3");
    bitv(1, 0, 0, 0, "gap_b3"); bitv(0, 0, 1, 1, "gap_b4");
    idle(0, 1, "gap_after");

    // Load with i_valid high: bit discarded, counter cleared, new pattern 1100.
    drive(1'b0, 1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "load_1100");
    bitv(1, 0, 0, 0, "ld_b1"); bitv(1, 0, 0, 0, "ld_b2");
    bitv(0, 0, 0, 0, "ld_b3"); bitv(0, 0, 1, 1, "ld_b4");

    // Reset wins over a simultaneous load: pattern returns to 1010.
    drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "rst_over_load");

    // Overlap switched off after an overlapping match; history is not flushed.
    bitv(1, 1, 0, 0, "sw_b1"); bitv(0, 1, 0, 0, "sw_b2");
    bitv(1, 1, 0, 0, "sw_b3"); bitv(0, 1, 1, 1, "sw_b4");
    bitv(1, 0, 0, 1, "sw_b5"); bitv(0, 0, 1, 2, "sw_b6");
    bitv(1, 0, 0, 2, "sw_b7"); bitv(0, 0, 0, 2, "sw_b8");

    // Load clears counters; then 1,0 x10 overlapping: 9 matches, CNT_W=2 saturates at 3.
    drive(1'b0, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, "load_sat");
    for (int k = 1; k <= 20; k++) begin
      int c;
      c = (k >= 4) ? (k - 2) / 2 : 0;
      drive(1'b0, 1'b0, 4'b0000, 1'b1, logic'(k % 2 == 1), 1'b1,
            logic'(k >= 4 && k % 2 == 0), c, (c > 3) ? 3 : c, $sformatf("sat_b%0d", k));
    end

    repeat (3) @(negedge clk);
    #1;
    check("drain", "pending", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
